// File: rtl/intr_ctrl_if.sv
// Bundle of request, configuration and core-side signals for intr_ctrl.
// slave = controller side, master = core/system side.
interface intr_ctrl_if #(
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq_i;
    logic             cfg_we_i;
    logic [N_IRQ-1:0] cfg_wdata_i;
    logic             int_ack_i;
    logic             int_done_i;
    logic             int_o;
    logic [31:0]      vec_o;
    logic             in_service_o;
    logic [N_IRQ-1:0] pending_o;
    logic [N_IRQ-1:0] mask_o;
    logic [1:0]       state_o;

    modport slave (
        input  irq_i, cfg_we_i, cfg_wdata_i, int_ack_i, int_done_i,
        output int_o, vec_o, in_service_o, pending_o, mask_o, state_o
    );

    modport master (
        output irq_i, cfg_we_i, cfg_wdata_i, int_ack_i, int_done_i,
        input  int_o, vec_o, in_service_o, pending_o, mask_o, state_o
    );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritized, non-nesting interrupt controller: edge-detects irq lines into pending,
// raises INT with a handler vector, holds one request in service. Option: INTC_SYNC_EN.
module intr_ctrl #(
    parameter int          N_IRQ    = 8,
    parameter logic [31:0] BASE_VEC = 32'h0000_0100
) (
    input  logic       clk,
    input  logic       rst_n,
    intr_ctrl_if.slave bus
);
    // Handshake: int_ack_i is honoured only while INT is held in REQ; int_done_i only
    // in SERVICE. Both are single-cycle pulses sampled on the rising clock edge.
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       vec_q, vec_d;
    logic              int_q, int_d;
    logic              insvc_q, insvc_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  prev_q;
    logic [N_IRQ-1:0]  irq_s;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  eligible;
    logic [N_IRQ-1:0]  clr;
    logic [ID_W-1:0]   winner;

`ifdef INTC_SYNC_EN
    logic [N_IRQ-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.irq_i;
            s2_q <= s1_q;
        end
    end

    assign irq_s = s2_q;
`else
    assign irq_s = bus.irq_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= irq_s;
    end

    assign rise     = irq_s & ~prev_q;
    assign eligible = pending_q & mask_q;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = i[ID_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        int_d   = int_q;
        insvc_d = insvc_q;
        clr     = '0;
        mask_d  = bus.cfg_we_i ? bus.cfg_wdata_i : mask_q;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    state_d = REQ;
                    id_d    = winner;
                    vec_d   = BASE_VEC + (32'(winner) << 2);
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (bus.int_ack_i) begin
                    clr[id_q] = 1'b1;
                    int_d     = 1'b0;
                    insvc_d   = 1'b1;
                    state_d   = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.int_done_i) begin
                    insvc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge on the line being cleared keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= '0;
            vec_q     <= '0;
            int_q     <= 1'b0;
            insvc_q   <= 1'b0;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
            int_q     <= int_d;
            insvc_q   <= insvc_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.int_o        = int_q;
    assign bus.vec_o        = vec_q;
    assign bus.in_service_o = insvc_q;
    assign bus.pending_o    = pending_q;
    assign bus.mask_o       = mask_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expected vectors queued at stimulus time and
// popped by a monitor on each INT rising edge; status outputs checked inline.
module tb_intr_ctrl;
  localparam int N = 8;
`ifdef INTC_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic int_prev;

  intr_ctrl_if #(.N_IRQ(N)) bus ();

  intr_ctrl #(.N_IRQ(N), .BASE_VEC(32'h0000_0100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.int_o && !int_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL vec_unexpected: act=%h exp=<none>", bus.vec_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.vec_o !== e) begin
          failures++;
          $display("FAIL vec: act=%h exp=%h", bus.vec_o, e);
        end
      end
    end
    int_prev <= bus.int_o;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_int();
    int n = 0;
    while (!bus.int_o && n < 30) begin
      tick(1);
      n++;
    end
    check("int_wait", {31'd0, bus.int_o}, 32'd1);
  endtask

  task automatic ack();
    bus.int_ack_i = 1'b1;
    tick(1);
    bus.int_ack_i = 1'b0;
    check("ack_int", {31'd0, bus.int_o}, 32'd0);
    check("ack_insvc", {31'd0, bus.in_service_o}, 32'd1);
  endtask

  task automatic done();
    bus.int_done_i = 1'b1;
    tick(1);
    bus.int_done_i = 1'b0;
    check("done_insvc", {31'd0, bus.in_service_o}, 32'd0);
  endtask

  task automatic cfg_write(input logic [N-1:0] m);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_wdata_i = m;
    tick(1);
    bus.cfg_we_i    = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_int", {31'd0, bus.int_o}, 32'd0);
    check("rst_vec", bus.vec_o, 32'd0);
    check("rst_insvc", {31'd0, bus.in_service_o}, 32'd0);
    check("rst_pending", {24'd0, bus.pending_o}, 32'd0);
    check("rst_mask", {24'd0, bus.mask_o}, 32'h0000_00FF);
    check("rst_state", {30'd0, bus.state_o}, 32'd0);
  endtask

  initial begin
    logic [N-1:0] p;
    rst_n = 1'b0;
    int_prev = 1'b0;
    bus.irq_i = 8'hFF;
    bus.cfg_we_i = 1'b0;
    bus.cfg_wdata_i = '0;
    bus.int_ack_i = 1'b0;
    bus.int_done_i = 1'b0;
    tick(3);
    check_reset_vals();

    // release with all lines high: each line latches once, served in index order
    exp_q.push_back(32'h100);
    rst_n = 1'b1;
    tick(1 + L);
    check("rel_pending", {24'd0, bus.pending_o}, 32'h0000_00FF);
    for (int i = 0; i < N; i++) begin
      wait_int();
      ack();
      p = 8'hFF << (i + 1);
      check("rel_clr", {24'd0, bus.pending_o}, {24'd0, p});
      tick(2);
      if (i < N - 1) exp_q.push_back(32'h100 + 32'(4 * (i + 1)));
      done();
    end
    tick(L + 4);
    check("held_no_retrig", {24'd0, bus.pending_o}, 32'd0);
    check("held_no_int", {31'd0, bus.int_o}, 32'd0);

    // single request on line 3
    bus.irq_i = 8'h00;
    tick(L + 2);
    exp_q.push_back(32'h10C);
    bus.irq_i = 8'h08;
    tick(1 + L);
    check("single_pending", {24'd0, bus.pending_o}, 32'h0000_0008);
    check("single_int_lo", {31'd0, bus.int_o}, 32'd0);
    tick(1);
    check("single_int_hi", {31'd0, bus.int_o}, 32'd1);
    check("single_vec", bus.vec_o, 32'h10C);
    tick(1);
    ack();
    check("single_clr", {24'd0, bus.pending_o}, 32'd0);
    tick(2);
    done();
    bus.irq_i = 8'h00;
    tick(L + 2);

    // priority: lines 5 and 2 together
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h114);
    bus.irq_i = 8'h24;
    wait_int();
    check("prio_vec", bus.vec_o, 32'h108);
    ack();
    check("prio_left", {24'd0, bus.pending_o}, 32'h0000_0020);
    done();
    wait_int();
    check("prio_vec2", bus.vec_o, 32'h114);
    ack();
    done();
    bus.irq_i = 8'h00;
    tick(L + 2);

    // mask: masked line latches but is not requested until unmasked
    cfg_write(8'hFE);
    check("mask_val", {24'd0, bus.mask_o}, 32'h0000_00FE);
    bus.irq_i = 8'h01;
    tick(1);
    bus.irq_i = 8'h00;
    tick(L + 3);
    check("mask_pending", {24'd0, bus.pending_o}, 32'h0000_0001);
    check("mask_int_lo", {31'd0, bus.int_o}, 32'd0);
    exp_q.push_back(32'h100);
    cfg_write(8'hFF);
    check("unmask_int_lo", {31'd0, bus.int_o}, 32'd0);
    tick(1);
    check("unmask_int_hi", {31'd0, bus.int_o}, 32'd1);
    check("unmask_vec", bus.vec_o, 32'h100);
    ack();
    done();
    tick(2);

    // race: new edge on line 1 lands on the ack edge for id 1
    exp_q.push_back(32'h104);
    bus.irq_i = 8'h02;
    wait_int();
    bus.irq_i = 8'h00;
    tick(L + 2);
    bus.irq_i = 8'h02;
    if (L > 0) tick(L);
    bus.int_ack_i = 1'b1;
    tick(1);
    bus.int_ack_i = 1'b0;
    check("race_pending", {24'd0, bus.pending_o}, 32'h0000_0002);
    check("race_insvc", {31'd0, bus.in_service_o}, 32'd1);
    check("race_int", {31'd0, bus.int_o}, 32'd0);
    exp_q.push_back(32'h104);
    tick(1);
    done();
    wait_int();
    check("race_vec", bus.vec_o, 32'h104);
    ack();
    done();
    bus.irq_i = 8'h00;
    tick(L + 2);

    // reset while in service with lines 4,5 pending
    exp_q.push_back(32'h108);
    bus.irq_i = 8'h04;
    wait_int();
    ack();
    bus.irq_i = 8'h34;
    tick(L + 2);
    check("mid_pending", {24'd0, bus.pending_o}, 32'h0000_0030);
    check("mid_insvc", {31'd0, bus.in_service_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    bus.irq_i = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    done();
    tick(3);
    check("stray_int", {31'd0, bus.int_o}, 32'd0);
    check("stray_pending", {24'd0, bus.pending_o}, 32'd0);
    check("stray_state", {30'd0, bus.state_o}, 32'd0);

    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
